audio_clip_controller: RTL and testbench
========================================

AUDIO_CLIP_CONTROLLER -- requirements
Module: audio_clip_controller

Interface
REQ-001 DATA_W, 16, sample width.
REQ-002 SLOT_W, 2, log2 clip-slot count; NUM_SLOTS = 2^SLOT_W.
REQ-003 OFS_W, 24, log2 samples per slot; ADDR_W = SLOT_W+OFS_W.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 cmd_valid  in  1  one-cycle command strobe.
REQ-007 cmd  in  3  opcode: 0 STOP, 1 RECORD, 2 PLAY, 3 PAUSE, 4 ERASE, 5 ERASE_ALL; 6-7 ignored.
REQ-008 cmd_slot  in  SLOT_W  target slot for RECORD/PLAY/ERASE.
REQ-009 loop_en  in  1  restart playback at offset 0 at clip end.
REQ-010 sample_tick  in  1  one-cycle pulse per audio sample period.
REQ-011 adc_sample  in  DATA_W  codec capture word.
REQ-012 dac_sample  out  DATA_W  playback word to codec.
REQ-013 playback  out  1  codec output sourced from RAM.
REQ-014 ram_rdy  in  1  RAM ready/calibrated.
REQ-015 ram_addr  out  ADDR_W  {slot, offset}.
REQ-016 ram_wdata  out  DATA_W; ram_we  out  1  one-cycle write pulse.
REQ-017 ram_rd_req  out  1; ram_rd_valid  in  1; ram_rd_data  in  DATA_W; ram_rd_ack  out  1.
REQ-018 state_o  out  3  state code; busy  out  1  state != IDLE.
REQ-019 clip_len_o  out  OFS_W+1  length of cmd_slot; overrun  out  1  sticky sample-drop flag.

Function
REQ-020 States and codes: IDLE 0, REC 1, REC_WR 2, PLAY 3, PLAY_RD 4, PLAY_ACK 5, PAUSE 6.
REQ-021 ram_rdy=0: FSM frozen, outputs held, cmd_valid dropped; resumes when ram_rdy=1.
REQ-022 IDLE: RECORD -> REC, slot latched, offset 0, len[slot] 0; PLAY with len>0 -> PLAY, offset 0 (len=0 ignored); ERASE clears len[cmd_slot]; ERASE_ALL clears all len in one cycle, no RAM writes.
REQ-023 REC: sample_tick registers adc_sample to ram_wdata, ram_addr={slot,offset} -> REC_WR.
REQ-024 REC_WR: ram_we=1 one cycle, len[slot]=offset+1, offset+1 -> REC; if offset was 2^OFS_W-1 -> IDLE (slot full, no wrap).
REQ-025 PLAY: sample_tick drives ram_addr, asserts ram_rd_req -> PLAY_RD; ram_rd_req held until ram_rd_valid.
REQ-026 PLAY_RD: ram_rd_valid -> dac_sample=ram_rd_data, ram_rd_req 0, ram_rd_ack 1 for one cycle -> PLAY_ACK.
REQ-027 PLAY_ACK: offset+1; if offset+1==len[slot]: loop_en=1 -> offset 0, PLAY; else IDLE; otherwise PLAY.
REQ-028 playback=1 in PLAY, PLAY_RD, PLAY_ACK, PAUSE; dac_sample held in PAUSE, cleared on IDLE entry.
REQ-029 PAUSE cmd in PLAY -> PAUSE; in PLAY_RD/PLAY_ACK latched pending, taken on return to PLAY; PLAY cmd in PAUSE resumes same offset.
REQ-030 STOP in any state -> IDLE, offset 0, after any in-flight RAM transaction completes (write pulse issued, read acked); RECORD/PLAY while busy ignored.
REQ-031 sample_tick in REC_WR, PLAY_RD or PLAY_ACK: sample dropped, overrun=1; cleared only by STOP or rst.
REQ-032 sample_tick coincident with STOP in REC/PLAY: STOP wins, no RAM access.
REQ-033 offset and len are OFS_W+1 bits; len saturates at 2^OFS_W.

Reset
REQ-034 rst: state IDLE, all len 0, offset 0, ram_addr/ram_wdata/dac_sample 0, ram_we/ram_rd_req/ram_rd_ack/playback/overrun/pending-pause 0.
REQ-035 rst mid-transaction abandons it; no RAM strobe in the cycle after rst.

Structure
REQ-036 Package audio_clip_pkg holds state encoding, opcode constants, default DATA_W/SLOT_W/OFS_W.
REQ-037 One sub-module clip_len_table: NUM_SLOTS x (OFS_W+1) register file, one write port, reads for active slot and cmd_slot, single-cycle clear-all.

Verification
REQ-038 SLOT_W=2, OFS_W=4; RECORD slot 1, ticks with 0x1111..0x5555, STOP -> 5 ram_we pulses at 0x10..0x14, clip_len_o=5.
REQ-039 PLAY slot 1, loop_en=0, RAM model 3-cycle latency -> dac_sample 0x1111..0x5555 in order, then IDLE, playback=0, dac_sample=0.
REQ-040 RECORD slot 2, 17 ticks -> last write at 0x2F, auto IDLE after 16th, no 17th write, len=16.
REQ-041 len=3, loop_en=1 -> read addresses 0,1,2,0,1,2; PAUSE after 2nd sample, ticks ignored, PLAY resumes at offset 2.
REQ-042 tick during PLAY_RD -> overrun=1, single ram_rd_req; STOP -> overrun=0, IDLE after ack.
REQ-043 rst in REC_WR -> ram_we 0 next cycle, all lengths 0, state_o=0.

Source files
------------

// File: rtl/audio_clip_pkg.sv
// Shared encodings for the audio clip record/playback controller:
// FSM state codes, command opcodes and default geometry.
package audio_clip_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SLOT_W = 2;
  localparam int DEF_OFS_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REC      = 3'd1,
    ST_REC_WR   = 3'd2,
    ST_PLAY     = 3'd3,
    ST_PLAY_RD  = 3'd4,
    ST_PLAY_ACK = 3'd5,
    ST_PAUSE    = 3'd6
  } state_t;

  localparam logic [2:0] OP_STOP      = 3'd0;
  localparam logic [2:0] OP_RECORD    = 3'd1;
  localparam logic [2:0] OP_PLAY      = 3'd2;
  localparam logic [2:0] OP_PAUSE     = 3'd3;
  localparam logic [2:0] OP_ERASE     = 3'd4;
  localparam logic [2:0] OP_ERASE_ALL = 3'd5;

endpackage

// File: rtl/clip_len_table.sv
// Per-slot clip length register file: one write port, two read ports
// (active slot and command slot) and a single-cycle clear of every entry.
module clip_len_table
  import audio_clip_pkg::*;
#(
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int OFS_W  = DEF_OFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SLOT_W-1:0] waddr,
  input  logic [OFS_W:0]    wdata,
  input  logic              clr_all,
  input  logic [SLOT_W-1:0] raddr_a,
  output logic [OFS_W:0]    rdata_a,
  input  logic [SLOT_W-1:0] raddr_b,
  output logic [OFS_W:0]    rdata_b
);

  localparam int NUM_SLOTS = 1 << SLOT_W;

  logic [OFS_W:0] len_q [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else if (we) begin
      len_q[waddr] <= wdata;
    end
  end

  assign rdata_a = len_q[raddr_a];
  assign rdata_b = len_q[raddr_b];

endmodule

// File: rtl/audio_clip_controller.sv
// Records codec samples into per-slot RAM regions and plays them back,
// one RAM access per sample_tick; lengths live in clip_len_table.
module audio_clip_controller
  import audio_clip_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int OFS_W  = DEF_OFS_W,
  localparam int ADDR_W = SLOT_W + OFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [SLOT_W-1:0] cmd_slot,
  input  logic              loop_en,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_sample,
  output logic [DATA_W-1:0] dac_sample,
  output logic              playback,
  input  logic              ram_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_rd_req,
  input  logic              ram_rd_valid,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_rd_ack,
  output logic [2:0]        state_o,
  output logic              busy,
  output logic [OFS_W:0]    clip_len_o,
  output logic              overrun
);

  localparam logic [OFS_W:0] OFS_ONE  = (OFS_W+1)'(1);
  localparam logic [OFS_W:0] LAST_OFS = {1'b0, {OFS_W{1'b1}}};

  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [OFS_W:0]    offset;
  logic [OFS_W:0]    offset_inc;
  logic [OFS_W:0]    len_act;
  logic [OFS_W:0]    len_cmd;
  logic              pause_pend;
  logic              stop_pend;
  logic              go_idle;

  logic              tbl_we;
  logic              tbl_clr;
  logic [SLOT_W-1:0] tbl_waddr;
  logic [OFS_W:0]    tbl_wdata;

  // Commands are only honoured while the RAM is ready.
  logic cmd_go, stop_cmd, play_cmd, pause_cmd;
  assign cmd_go    = cmd_valid & ram_rdy;
  assign stop_cmd  = cmd_go && (cmd == OP_STOP);
  assign play_cmd  = cmd_go && (cmd == OP_PLAY);
  assign pause_cmd = cmd_go && (cmd == OP_PAUSE);

  assign offset_inc = offset + OFS_ONE;

  clip_len_table #(.SLOT_W(SLOT_W), .OFS_W(OFS_W)) u_len (
    .clk     (clk),
    .rst     (rst),
    .we      (tbl_we),
    .waddr   (tbl_waddr),
    .wdata   (tbl_wdata),
    .clr_all (tbl_clr),
    .raddr_a (slot),
    .rdata_a (len_act),
    .raddr_b (cmd_slot),
    .rdata_b (len_cmd)
  );

  always_comb begin
    tbl_we    = 1'b0;
    tbl_clr   = 1'b0;
    tbl_waddr = slot;
    tbl_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_go && (cmd == OP_RECORD || cmd == OP_ERASE)) begin
          tbl_we    = 1'b1;
          tbl_waddr = cmd_slot;
        end else if (cmd_go && cmd == OP_ERASE_ALL) begin
          tbl_clr = 1'b1;
        end
      end
      ST_REC_WR: begin
        tbl_we    = ram_rdy;
        tbl_wdata = offset_inc;
      end
      default: ;
    endcase
  end

  // A pending STOP in the read path is honoured only once the ack cycle is done.
  always_comb begin
    go_idle = 1'b0;
    case (state)
      ST_IDLE, ST_REC, ST_PLAY, ST_PAUSE: go_idle = stop_cmd;
      ST_REC_WR:   go_idle = stop_cmd || (offset == LAST_OFS);
      ST_PLAY_ACK: go_idle = stop_cmd || stop_pend || ((offset_inc >= len_act) && !loop_en);
      default:     go_idle = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      slot       <= '0;
      offset     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      ram_rd_req <= 1'b0;
      ram_rd_ack <= 1'b0;
      dac_sample <= '0;
      playback   <= 1'b0;
      overrun    <= 1'b0;
      pause_pend <= 1'b0;
      stop_pend  <= 1'b0;
    end else if (ram_rdy) begin
      ram_we     <= 1'b0;
      ram_rd_ack <= 1'b0;

      if (stop_cmd || (state == ST_PLAY_ACK && stop_pend))
        overrun <= 1'b0;
      else if (sample_tick && (state == ST_REC_WR || state == ST_PLAY_RD || state == ST_PLAY_ACK))
        overrun <= 1'b1;

      if (go_idle) begin
        state      <= ST_IDLE;
        offset     <= '0;
        dac_sample <= '0;
        playback   <= 1'b0;
        pause_pend <= 1'b0;
        stop_pend  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_go && cmd == OP_RECORD) begin
              state  <= ST_REC;
              slot   <= cmd_slot;
              offset <= '0;
            end else if (play_cmd && len_cmd != '0) begin
              state    <= ST_PLAY;
              slot     <= cmd_slot;
              offset   <= '0;
              playback <= 1'b1;
            end
          end
          ST_REC: begin
            if (sample_tick) begin
              ram_wdata <= adc_sample;
              ram_addr  <= {slot, offset[OFS_W-1:0]};
              ram_we    <= 1'b1;
              state     <= ST_REC_WR;
            end
          end
          ST_REC_WR: begin
            offset <= offset_inc;
            state  <= ST_REC;
          end
          ST_PLAY: begin
            if (pause_cmd || pause_pend) begin
              state      <= ST_PAUSE;
              pause_pend <= 1'b0;
            end else if (sample_tick) begin
              ram_addr   <= {slot, offset[OFS_W-1:0]};
              ram_rd_req <= 1'b1;
              state      <= ST_PLAY_RD;
            end
          end
          ST_PLAY_RD: begin
            if (stop_cmd)  stop_pend  <= 1'b1;
            if (pause_cmd) pause_pend <= 1'b1;
            if (ram_rd_valid) begin
              dac_sample <= ram_rd_data;
              ram_rd_req <= 1'b0;
              ram_rd_ack <= 1'b1;
              state      <= ST_PLAY_ACK;
            end
          end
          ST_PLAY_ACK: begin
            if (pause_cmd) pause_pend <= 1'b1;
            offset <= (offset_inc >= len_act) ? '0 : offset_inc;
            state  <= ST_PLAY;
          end
          ST_PAUSE: begin
            if (play_cmd) state <= ST_PLAY;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_o    = state;
  assign busy       = (state != ST_IDLE);
  assign clip_len_o = len_cmd;

endmodule

// File: tb/tb_audio_clip_controller.sv
// Directed bench for audio_clip_controller with a small RAM model
// (3-cycle read latency) and hand-computed expectations.
module tb_audio_clip_controller;
  import audio_clip_pkg::*;

  localparam int DATA_W = 16;
  localparam int SLOT_W = 2;
  localparam int OFS_W  = 4;
  localparam int ADDR_W = SLOT_W + OFS_W;
  localparam int WR_W   = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [SLOT_W-1:0] cmd_slot;
  logic              loop_en;
  logic              sample_tick;
  logic [DATA_W-1:0] adc_sample;
  logic [DATA_W-1:0] dac_sample;
  logic              playback;
  logic              ram_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_rd_req;
  logic              ram_rd_valid;
  logic [DATA_W-1:0] ram_rd_data;
  logic              ram_rd_ack;
  logic [2:0]        state_o;
  logic              busy;
  logic [OFS_W:0]    clip_len_o;
  logic              overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WR_W-1:0]   exp_q[$];
  logic [WR_W-1:0]   wr_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  int                rd_req_cnt;
  int                rd_lat;
  logic              req_prev;

  audio_clip_controller #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .OFS_W(OFS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_slot     (cmd_slot),
    .loop_en      (loop_en),
    .sample_tick  (sample_tick),
    .adc_sample   (adc_sample),
    .dac_sample   (dac_sample),
    .playback     (playback),
    .ram_rdy      (ram_rdy),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rd_req   (ram_rd_req),
    .ram_rd_valid (ram_rd_valid),
    .ram_rd_data  (ram_rd_data),
    .ram_rd_ack   (ram_rd_ack),
    .state_o      (state_o),
    .busy         (busy),
    .clip_len_o   (clip_len_o),
    .overrun      (overrun)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  // RAM model: logs writes, answers each read request after 3 cycles
  initial begin
    ram_rd_valid = 1'b0;
    ram_rd_data  = '0;
    rd_lat       = 0;
    req_prev     = 1'b0;
    rd_req_cnt   = 0;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        wr_q.push_back({ram_addr, ram_wdata});
        mem[ram_addr] = ram_wdata;
      end
      if (ram_rd_req && !req_prev) rd_req_cnt++;
      req_prev = ram_rd_req;
      if (ram_rd_valid) begin
        ram_rd_valid = 1'b0;
      end else if (ram_rd_req) begin
        rd_lat++;
        if (rd_lat == 3) begin
          ram_rd_valid = 1'b1;
          ram_rd_data  = mem[ram_addr];
          rd_addr_q.push_back(ram_addr);
          rd_lat = 0;
        end
      end
    end
  end

  // Driver tasks
  task automatic send_cmd(input logic [2:0] op, input logic [SLOT_W-1:0] s);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = op;
    cmd_slot  = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic tick(input logic [DATA_W-1:0] d);
    @(negedge clk);
    adc_sample  = d;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget);
    int n;
    n = 0;
    while (state_o !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({ram_we, ram_rd_req, ram_rd_ack, playback, overrun} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000", {ram_we, ram_rd_req, ram_rd_ack, playback, overrun});
    end
    n_cmp++; if ({ram_addr, ram_wdata, dac_sample} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h dac %h want all 0", ram_addr, ram_wdata, dac_sample);
    end
    n_cmp++; if (clip_len_o !== '0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", clip_len_o); end
  endtask

  task automatic test_record();
    wr_q.delete();
    exp_q.delete();
    send_cmd(OP_RECORD, 2'd1);
    n_cmp++; if (state_o !== 3'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rec_enter: state %0d busy %b want 1/1", state_o, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick(DATA_W'(16'h1111 * (i + 1)));
      exp_q.push_back({ADDR_W'(16 + i), DATA_W'(16'h1111 * (i + 1))});
      repeat (2) @(negedge clk);
    end
    send_cmd(OP_STOP, 2'd1);
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rec_stop_state: got %0d want 0", state_o); end
    n_cmp++; if (wr_q.size() !== 5) begin n_fail++; $display("FAIL rec_wr_count: got %0d want 5", wr_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rec_wr[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++; if (clip_len_o !== 5'd5) begin n_fail++; $display("FAIL rec_len: got %0d want 5", clip_len_o); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rec_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_play();
    int base;
    base = rd_req_cnt;
    rd_addr_q.delete();
    loop_en = 1'b0;
    send_cmd(OP_PLAY, 2'd1);
    n_cmp++; if (state_o !== 3'd3 || playback !== 1'b1) begin
      n_fail++; $display("FAIL play_enter: state %0d playback %b want 3/1", state_o, playback);
    end
    for (int i = 0; i < 5; i++) begin
      tick(16'h0);
      wait_state(3'd5, 20);
      n_cmp++; if (state_o !== 3'd5 || ram_rd_ack !== 1'b1) begin
        n_fail++; $display("FAIL play_ack[%0d]: state %0d ack %b want 5/1", i, state_o, ram_rd_ack);
      end
      n_cmp++; if (dac_sample !== DATA_W'(16'h1111 * (i + 1))) begin
        n_fail++; $display("FAIL play_dac[%0d]: got %h want %h", i, dac_sample, DATA_W'(16'h1111 * (i + 1)));
      end
      @(negedge clk);
      if (i < 4) begin
        n_cmp++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL play_back[%0d]: got %0d want 3", i, state_o); end
      end else begin
        n_cmp++; if (state_o !== 3'd0 || playback !== 1'b0 || dac_sample !== '0) begin
          n_fail++; $display("FAIL play_end: state %0d playback %b dac %h want 0/0/0", state_o, playback, dac_sample);
        end
      end
    end
    n_cmp++; if (rd_req_cnt - base !== 5) begin n_fail++; $display("FAIL play_req_count: got %0d want 5", rd_req_cnt - base); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (i >= rd_addr_q.size() || rd_addr_q[i] !== ADDR_W'(16 + i)) begin
        n_fail++; $display("FAIL play_addr[%0d]: got %h want %h", i, (i < rd_addr_q.size()) ? rd_addr_q[i] : '0, ADDR_W'(16 + i));
      end
    end
  endtask

  task automatic test_full_slot();
    wr_q.delete();
    send_cmd(OP_RECORD, 2'd2);
    for (int i = 0; i < 17; i++) tick(DATA_W'(16'hA000 + i));
    @(negedge clk);
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL full_state: got %0d want 0", state_o); end
    n_cmp++; if (wr_q.size() !== 16) begin n_fail++; $display("FAIL full_wr_count: got %0d want 16", wr_q.size()); end
    n_cmp++; if (wr_q.size() < 16 || wr_q[15] !== {6'h2F, 16'hA00F}) begin
      n_fail++; $display("FAIL full_last_wr: got %h want %h", (wr_q.size() > 15) ? wr_q[15] : '0, {6'h2F, 16'hA00F});
    end
    n_cmp++; if (clip_len_o !== 5'd16) begin n_fail++; $display("FAIL full_len: got %0d want 16", clip_len_o); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL full_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_loop_pause();
    send_cmd(OP_RECORD, 2'd3);
    for (int i = 0; i < 3; i++) tick(DATA_W'(16'h3A00 + i));
    send_cmd(OP_STOP, 2'd3);
    n_cmp++; if (clip_len_o !== 5'd3) begin n_fail++; $display("FAIL loop_len: got %0d want 3", clip_len_o); end
    rd_addr_q.delete();
    loop_en = 1'b1;
    send_cmd(OP_PLAY, 2'd3);
    for (int i = 0; i < 6; i++) begin
      tick(16'h0);
      if (i == 4) send_cmd(OP_PAUSE, 2'd3);
      wait_state(3'd5, 20);
      n_cmp++; if (dac_sample !== DATA_W'(16'h3A00 + (i % 3))) begin
        n_fail++; $display("FAIL loop_dac[%0d]: got %h want %h", i, dac_sample, DATA_W'(16'h3A00 + (i % 3)));
      end
      if (i == 1) send_cmd(OP_PAUSE, 2'd3);
      if (i == 1 || i == 4) begin
        wait_state(3'd6, 5);
        n_cmp++; if (state_o !== 3'd6 || playback !== 1'b1) begin
          n_fail++; $display("FAIL pause_enter[%0d]: state %0d playback %b want 6/1", i, state_o, playback);
        end
        tick(16'h0);
        n_cmp++; if (state_o !== 3'd6 || ram_rd_req !== 1'b0 || overrun !== 1'b0) begin
          n_fail++; $display("FAIL pause_tick[%0d]: state %0d req %b overrun %b want 6/0/0", i, state_o, ram_rd_req, overrun);
        end
        n_cmp++; if (dac_sample !== DATA_W'(16'h3A00 + (i % 3))) begin
          n_fail++; $display("FAIL pause_hold[%0d]: got %h want %h", i, dac_sample, DATA_W'(16'h3A00 + (i % 3)));
        end
        send_cmd(OP_PLAY, 2'd3);
        n_cmp++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL pause_resume[%0d]: got %0d want 3", i, state_o); end
      end
    end
    send_cmd(OP_STOP, 2'd3);
    loop_en = 1'b0;
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL loop_stop: got %0d want 0", state_o); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (i >= rd_addr_q.size() || rd_addr_q[i] !== ADDR_W'(48 + (i % 3))) begin
        n_fail++; $display("FAIL loop_addr[%0d]: got %h want %h", i, (i < rd_addr_q.size()) ? rd_addr_q[i] : '0, ADDR_W'(48 + (i % 3)));
      end
    end
  endtask

  task automatic test_overrun();
    int base;
    send_cmd(OP_PLAY, 2'd1);
    base = rd_req_cnt;
    tick(16'h0);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_cmp++; if (overrun !== 1'b1 || state_o !== 3'd4) begin
      n_fail++; $display("FAIL ovr_set: overrun %b state %0d want 1/4", overrun, state_o);
    end
    cmd_valid = 1'b1;
    cmd       = OP_STOP;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (state_o !== 3'd5 || ram_rd_ack !== 1'b1) begin
      n_fail++; $display("FAIL ovr_ack: state %0d ack %b want 5/1", state_o, ram_rd_ack);
    end
    @(negedge clk);
    n_cmp++; if (state_o !== 3'd0 || overrun !== 1'b0 || dac_sample !== '0) begin
      n_fail++; $display("FAIL ovr_stop: state %0d overrun %b dac %h want 0/0/0", state_o, overrun, dac_sample);
    end
    n_cmp++; if (rd_req_cnt - base !== 1) begin n_fail++; $display("FAIL ovr_req_count: got %0d want 1", rd_req_cnt - base); end
  endtask

  task automatic test_erase();
    wr_q.delete();
    send_cmd(OP_ERASE, 2'd2);
    #1;
    n_cmp++; if (clip_len_o !== 5'd0) begin n_fail++; $display("FAIL erase_slot2: got %0d want 0", clip_len_o); end
    cmd_slot = 2'd1;
    #1;
    n_cmp++; if (clip_len_o !== 5'd5) begin n_fail++; $display("FAIL erase_keep1: got %0d want 5", clip_len_o); end
    send_cmd(OP_PLAY, 2'd2);
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL play_empty: got %0d want 0", state_o); end
    send_cmd(OP_ERASE_ALL, 2'd0);
    cmd_slot = 2'd1;
    #1;
    n_cmp++; if (clip_len_o !== 5'd0) begin n_fail++; $display("FAIL erase_all1: got %0d want 0", clip_len_o); end
    cmd_slot = 2'd3;
    #1;
    n_cmp++; if (clip_len_o !== 5'd0) begin n_fail++; $display("FAIL erase_all3: got %0d want 0", clip_len_o); end
    n_cmp++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL erase_ram_wr: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_ram_rdy();
    @(negedge clk);
    ram_rdy = 1'b0;
    send_cmd(OP_RECORD, 2'd0);
    ram_rdy = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rdy_drop_cmd: got %0d want 0", state_o); end
    send_cmd(OP_RECORD, 2'd0);
    ram_rdy = 1'b0;
    tick(16'h7777);
    n_cmp++; if (state_o !== 3'd1 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL rdy_freeze: state %0d we %b want 1/0", state_o, ram_we);
    end
    ram_rdy = 1'b1;
    send_cmd(OP_STOP, 2'd0);
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rdy_stop: got %0d want 0", state_o); end
  endtask

  task automatic test_reset_mid();
    send_cmd(OP_RECORD, 2'd0);
    tick(16'h0A0A);
    @(negedge clk);
    tick(16'h0B0B);
    n_cmp++; if (state_o !== 3'd2 || ram_we !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: state %0d we %b want 2/1", state_o, ram_we);
    end
    n_cmp++; if (clip_len_o !== 5'd1) begin n_fail++; $display("FAIL rstmid_len_pre: got %0d want 1", clip_len_o); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b0 || ram_rd_req !== 1'b0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_post: we %b req %b state %0d want 0/0/0", ram_we, ram_rd_req, state_o);
    end
    for (int s = 0; s < 4; s++) begin
      cmd_slot = SLOT_W'(s);
      #1;
      n_cmp++; if (clip_len_o !== 5'd0) begin n_fail++; $display("FAIL rstmid_len[%0d]: got %0d want 0", s, clip_len_o); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd         = 3'd0;
    cmd_slot    = '0;
    loop_en     = 1'b0;
    sample_tick = 1'b0;
    adc_sample  = '0;
    ram_rdy     = 1'b1;
    test_reset();
    test_record();
    test_play();
    test_full_slot();
    test_loop_pause();
    test_overrun();
    test_erase();
    test_ram_rdy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
